// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame data width and the
// bit-period helper used by both the transmitter and the receiver, so the two
// sides always agree on bit timing.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    s_idle,
    s_start_bit,
    s_data,
    s_stop_bit
  } tx_state_t;

  // One bit period in clocks for a given half-bit count.
  function automatic int bit_period(input int half);
    return 2 * half;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word-fall-through read.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (pointers/count only)
//   push, wdata    : write request and data; ignored while full
//   pop, rdata     : read request and head-of-queue data (valid when !empty)
//   count          : number of stored entries, one bit wider than the pointers
//   full, empty    : occupancy flags derived from count
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, with a byte FIFO in front of the shifter.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   sdata        : byte offered by the producer
//   sdata_valid  : producer offers sdata this cycle
//   sdata_ready  : FIFO can accept (registered, no path from sdata_valid)
//   txd          : registered serial output, idle high
//   busy         : FIFO non-empty or a frame in progress
//   fifo_count   : bytes queued, excluding the byte being shifted
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    sdata,
  input  logic                          sdata_valid,
  output logic                          sdata_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BP = bit_period(CLK_PER_HALF_BIT);
  localparam int CW = $clog2(BP);
  localparam logic [CW-1:0] CNT_LAST = CW'(BP - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  tx_state_t      state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     idx, idx_n;
  logic [7:0]     shift, shift_n;
  logic           txd_n;
  logic           pop;
  logic           push;
  logic           bit_end;
  logic [7:0]     fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;

  assign sdata_ready = ~fifo_full;
  assign push        = sdata_valid & sdata_ready & ~reset;
  assign busy        = (state != s_idle) | (fifo_count != '0);
  assign bit_end     = (cnt == CNT_LAST);

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (sdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= s_idle;
      txd   <= 1'b1;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      txd   <= txd_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = bit_end ? '0 : cnt + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    txd_n   = txd;
    pop     = 1'b0;
    case (state)
      s_idle: begin
        txd_n = 1'b1;
        cnt_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_rdata;
          txd_n   = 1'b0;
          state_n = s_start_bit;
        end
      end
      s_start_bit: begin
        if (bit_end) begin
          txd_n   = shift[0];
          idx_n   = '0;
          state_n = s_data;
        end
      end
      s_data: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          idx_n   = idx + 1'b1;
          if (idx == IDX_LAST) begin
            txd_n   = 1'b1;
            state_n = s_stop_bit;
          end else begin
            // The next data bit is what becomes shift[0] after this shift.
            txd_n = shift[1];
          end
        end
      end
      s_stop_bit: begin
        if (bit_end) begin
          // Chain straight into the next start bit so frames sit back to back.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_rdata;
            txd_n   = 1'b0;
            state_n = s_start_bit;
          end else begin
            txd_n   = 1'b1;
            state_n = s_idle;
          end
        end
      end
      default: begin
        txd_n   = 1'b1;
        state_n = s_idle;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int HB = 2;
  localparam int BP = 2 * HB;
  localparam int FRAME = 10 * BP;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sdata = 8'h77;
  logic       sdata_valid = 1'b1;
  logic       sdata_ready;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int start_cyc[$];

  uart_tx #(
    .CLK_PER_HALF_BIT (HB),
    .FIFO_DEPTH       (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sdata       (sdata),
    .sdata_valid (sdata_valid),
    .sdata_ready (sdata_ready),
    .txd         (txd),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    sdata = b;
    sdata_valid = 1'b1;
    while (!sdata_ready && n < 200) begin
      step();
      n++;
    end
    if (!sdata_ready) check("push_wait_timeout", 32'd0, 32'd1);
    else begin
      exp_q.push_back(b);
      step();
    end
    sdata_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  // Receiver model: on a start bit, pop the expected byte and check every
  // cycle of the frame against the ideal 8N1 waveform.
  initial begin : monitor
    logic [7:0] eb, got;
    logic       ok, have, abort, e;
    int         bi;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || txd !== 1'b0) continue;
      start_cyc.push_back(cyc);
      have = (exp_q.size() != 0);
      eb = have ? exp_q.pop_front() : 8'h00;
      ok = 1'b1;
      got = 8'h00;
      abort = 1'b0;
      for (int c = 0; c < FRAME; c++) begin
        if (c > 0) @(negedge clk);
        if (reset !== 1'b0) begin
          abort = 1'b1;
          break;
        end
        bi = c / BP;
        e = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : eb[bi-1];
        if (txd !== e) ok = 1'b0;
        if ((c % BP) == HB && bi >= 1 && bi <= 8) got[bi-1] = txd;
      end
      if (!abort) begin
        check("frame_expected", have, 1'b1);
        check("rx_byte", got, eb);
        check("frame_wave", ok, 1'b1);
      end
    end
  end

  initial begin : stim
    int t0, n, s, nf, rc;
    logic hold_hi;

    // Reset with valid held high: nothing may be queued or sent.
    repeat (3) step();
    reset = 1'b0;
    sdata_valid = 1'b0;
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    check("rst_ready", sdata_ready, 1'b1);
    repeat (20) step();
    check("rst_no_frame", start_cyc.size(), 32'd0);
    check("rst_count_later", fifo_count, 3'd0);

    // Single byte: latency, waveform and busy duration.
    push_byte(8'h55);
    check("lat_edge_k_txd", txd, 1'b1);
    check("lat_edge_k_count", fifo_count, 3'd1);
    check("lat_edge_k_busy", busy, 1'b1);
    step();
    check("lat_edge_k1_txd", txd, 1'b0);
    check("lat_edge_k1_count", fifo_count, 3'd0);
    t0 = cyc;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check("busy_fall_cycles", cyc - t0, FRAME);
    repeat (5) step();

    // Back to back: two frames exactly one frame apart.
    nf = start_cyc.size();
    push_byte(8'hA5);
    push_byte(8'h3C);
    wait_idle(200);
    check("b2b_frames", start_cyc.size() - nf, 32'd2);
    if (start_cyc.size() >= nf + 2)
      check("b2b_gap", start_cyc[nf+1] - start_cyc[nf], FRAME);
    repeat (5) step();

    // FIFO full: one byte in the shifter, four queued, sixth held.
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
    check("full_count", fifo_count, 3'd4);
    check("full_ready", sdata_ready, 1'b0);
    sdata = 8'h15;
    sdata_valid = 1'b1;
    n = 0;
    while (!sdata_ready && n < 200) begin
      step();
      n++;
    end
    rc = cyc;
    check("ready_return_cycle", rc - start_cyc[$], FRAME);
    check("ready_return_count", fifo_count, 3'd3);
    exp_q.push_back(8'h15);
    step();
    sdata_valid = 1'b0;
    check("sixth_pushed_count", fifo_count, 3'd4);
    wait_idle(600);
    check("full_all_sent", exp_q.size(), 32'd0);
    repeat (5) step();

    // Reset mid-frame during data bit 3 with two bytes queued.
    push_byte(8'hFF);
    push_byte(8'h12);
    push_byte(8'h34);
    check("mid_queued", fifo_count, 3'd2);
    s = start_cyc[$];
    n = 0;
    while (cyc < s + 4 * BP + 1 && n < 100) begin
      step();
      n++;
    end
    reset = 1'b1;
    step();
    check("mid_rst_txd", txd, 1'b1);
    check("mid_rst_count", fifo_count, 3'd0);
    check("mid_rst_busy", busy, 1'b0);
    reset = 1'b0;
    exp_q.delete();
    nf = start_cyc.size();
    hold_hi = 1'b1;
    repeat (60) begin
      step();
      if (txd !== 1'b1) hold_hi = 1'b0;
    end
    check("mid_line_idle", hold_hi, 1'b1);
    check("mid_no_resend", start_cyc.size() - nf, 32'd0);

    // All byte values back to back through the receiver model.
    nf = start_cyc.size();
    for (int i = 0; i < 256; i++) push_byte(8'(i));
    wait_idle(15000);
    check("all_frames", start_cyc.size() - nf, 32'd256);
    check("all_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, 8N1, LSB first. It is the send-side counterpart of UART_RX and uses the same bit timing, so a UART_RX built with the same CLK_PER_HALF_BIT receives its frames with ferr=0. A small byte FIFO with a valid/ready handshake decouples the producer (core / MMIO write) from the serial line. txd is driven straight to the board pin.

Parameters:
CLK_PER_HALF_BIT, 5208, clocks per half bit; one bit period = 2*CLK_PER_HALF_BIT clocks (must be >=1).
FIFO_DEPTH, 4, byte FIFO entries; power of two, >=2.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sdata  input  8  byte to send
sdata_valid  input  1  producer offers sdata this cycle
sdata_ready  output  1  FIFO can accept; push occurs on a rising edge where sdata_valid & sdata_ready
txd  output  1  serial line, idle high
busy  output  1  FIFO non-empty or frame in progress
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte being shifted

Behaviour:
- Reset (sampled at the rising edge while reset=1): txd=1, state=s_idle, FIFO empty (fifo_count=0), bit counter=0, busy=0. sdata_valid is ignored while reset=1. sdata_ready=1 immediately after reset.
- Reset mid-frame aborts the frame. txd=1 after the reset edge, queued bytes are discarded, and no partial byte is resent.
- sdata_ready = (fifo_count != FIFO_DEPTH). It is derived from registers only, with no combinational path from sdata_valid.
- A push while full is impossible by the handshake. A valid with ready=0 is simply held by the producer and is not an error.
- Same-cycle push and pop: both take effect and fifo_count is unchanged. When full, no push can occur even if a pop happens that cycle; ready rises on the next cycle.
- FSM states are s_idle, s_start_bit, s_data, s_stop_bit.
  - s_idle: if FIFO non-empty, then at the edge: pop the head into an 8-bit shift register, txd<=0, bit counter<=0, go to s_start_bit. Otherwise txd=1.
  - s_start_bit: hold txd=0 for exactly 2*CLK_PER_HALF_BIT clocks. Then txd<=shift[0], bit index<=0, go to s_data.
  - s_data: each bit is held exactly one bit period. At the end of the period, shift right and increment the index. After index 7 completes, txd<=1 and go to s_stop_bit.
  - s_stop_bit: hold txd=1 for one full bit period. At the end, if FIFO non-empty, pop and start the next start bit at that same edge (no idle gap, so back-to-back frames are exactly 10 bit periods apart). Otherwise go to s_idle.
- Latency: with FIFO empty and FSM idle, a push at edge k gives txd=0 after edge k+1.
- txd is a registered output and is glitch-free.
- Bit counter: counts 0..2*CLK_PER_HALF_BIT-1, wraps to 0 at each bit boundary, and is cleared on frame start. Width is $clog2(2*CLK_PER_HALF_BIT).
- busy = (state != s_idle) | (fifo_count != 0).

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum (s_idle, s_start_bit, s_data, s_stop_bit);
  - DATA_BITS=8;
  - a function bit_period(half) = 2*half, shared with UART_RX timing.
- Sub-module uart_fifo: synchronous FIFO parameterised by WIDTH and DEPTH.
  - Ports: clk, reset, push, wdata, pop, rdata (head, first-word-fall-through), count, full, empty.
  - Pointers wrap modulo DEPTH; count has one extra bit to distinguish full from empty.
- uart_tx contains the FSM, the bit counter and the shift register.

Test Plan:
- Reset with CLK_PER_HALF_BIT=2: assert reset for 3 cycles with sdata_valid=1 -> txd=1, busy=0, fifo_count=0, sdata_ready=1 after release; no frame is ever sent.
- Single byte 0x55, CLK_PER_HALF_BIT=2 (bit period 4): push at edge k -> txd=0 during cycles k+1..k+4, then 1,0,1,0,1,0,1,0 each for 4 cycles, then stop=1 for 4 cycles. busy falls 40 cycles after txd first goes low.
- Back-to-back: push 0xA5 then 0x3C on consecutive cycles -> two frames, with the second start bit 40 cycles after the first and no idle cycle between them. Decoded bytes are 0xA5 then 0x3C.
- FIFO full, FIFO_DEPTH=4: push 6 bytes continuously.
  - The first byte is popped into the shifter and the next 4 fill the FIFO, so sdata_ready=0 with fifo_count=4.
  - The 6th byte is held until the first stop bit ends; it is pushed the cycle after ready returns.
  - All 6 bytes are sent in order.
- Reset mid-frame: reset during data bit 3 of 0xFF with 2 bytes queued -> txd=1 after the reset edge, fifo_count=0, and the line stays idle.
- Loopback: txd into UART_RX (same CLK_PER_HALF_BIT=4), send all 256 byte values back-to-back -> each rdata equals the sent byte, ferr=0 for every frame.
